// File: rtl/clock_pkg.sv
// Shared BCD types, constants and helpers for the time-of-day counter.
// Values are two-digit packed BCD: {tens[7:4], ones[3:0]}.
package clock_pkg;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t BCD_59 = 8'h59;
  localparam bcd2_t BCD_23 = 8'h23;
  localparam bcd2_t BCD_12 = 8'h12;
  localparam bcd2_t BCD_11 = 8'h11;
  localparam bcd2_t BCD_01 = 8'h01;

  // Adds one with decimal carry from the ones digit into the tens digit.
  function automatic bcd2_t bcd_inc(input bcd2_t v);
    bcd2_t r;
    if (v[3:0] == 4'd9) begin
      r[7:4] = v[7:4] + 4'd1;
      r[3:0] = 4'd0;
    end else begin
      r[7:4] = v[7:4];
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd2_t to_bcd(input int unsigned v);
    bcd2_t r;
    r[7:4] = 4'((v / 10) % 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/time_counter_if.sv
// Set-mode controls and BCD time outputs of time_counter.
// The pm flag exists only when TWELVE_HOUR_EN is defined.
interface time_counter_if;
  import clock_pkg::*;

  logic  set_mode;
  logic  inc_hour;
  logic  inc_min;
  bcd2_t hour;
  bcd2_t minute;
  bcd2_t second;
  logic  sec_tick;
`ifdef TWELVE_HOUR_EN
  logic  pm;

  modport master (output set_mode, inc_hour, inc_min,
                  input  hour, minute, second, sec_tick, pm);
  modport slave  (input  set_mode, inc_hour, inc_min,
                  output hour, minute, second, sec_tick, pm);
`else
  modport master (output set_mode, inc_hour, inc_min,
                  input  hour, minute, second, sec_tick);
  modport slave  (input  set_mode, inc_hour, inc_min,
                  output hour, minute, second, sec_tick);
`endif

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MODULUS-1 -> 00. Carry flags the wrap
// only for counting via enable; set-mode steps via step never carry.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int unsigned MODULUS = 60
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  enable,
  input  logic  step,
  input  logic  clear,
  output bcd2_t value,
  output logic  carry
);

  localparam bcd2_t LAST = to_bcd(MODULUS - 1);

  bcd2_t value_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else if (clear) begin
      value_q <= '0;
    end else if (enable || step) begin
      value_q <= (value_q == LAST) ? bcd2_t'(0) : bcd_inc(value_q);
    end
  end

  assign value = value_q;
  assign carry = enable && (value_q == LAST);

endmodule

// File: rtl/time_counter.sv
// Real-time-of-day counter: 1 Hz prescaler plus BCD hh:mm:ss with set mode.
// Define TWELVE_HOUR_EN for the 12-hour build (hours 01-12 with pm flag).
module time_counter
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  time_counter_if.slave  bus
);

  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] PRE_LAST = W'(CLK_HZ - 1);

  logic [W-1:0] pre_cnt;
  logic         tick_run;
  logic         sec_tick_q;
  logic         sec_carry;
  logic         min_carry;
  logic         hour_step;
  bcd2_t        sec_val;
  bcd2_t        min_val;
  bcd2_t        hour_q;

  // Set mode overrides a coincident terminal count, so no second is lost or gained.
  assign tick_run = !bus.set_mode && (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt    <= '0;
      sec_tick_q <= 1'b0;
    end else begin
      sec_tick_q <= tick_run;
      if (bus.set_mode || pre_cnt == PRE_LAST) pre_cnt <= '0;
      else                                     pre_cnt <= pre_cnt + W'(1);
    end
  end

  bcd_mod_counter #(.MODULUS(60)) u_sec (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (tick_run),
    .step   (1'b0),
    .clear  (bus.set_mode),
    .value  (sec_val),
    .carry  (sec_carry)
  );

  bcd_mod_counter #(.MODULUS(60)) u_min (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (sec_carry),
    .step   (bus.set_mode && bus.inc_min),
    .clear  (1'b0),
    .value  (min_val),
    .carry  (min_carry)
  );

  assign hour_step = min_carry || (bus.set_mode && bus.inc_hour);

`ifdef TWELVE_HOUR_EN
  logic pm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour_q <= BCD_12;
      pm_q   <= 1'b0;
    end else if (hour_step) begin
      if (hour_q == BCD_12) begin
        hour_q <= BCD_01;
      end else begin
        if (hour_q == BCD_11) pm_q <= ~pm_q;
        hour_q <= bcd_inc(hour_q);
      end
    end
  end

  assign bus.pm = pm_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour_q <= '0;
    end else if (hour_step) begin
      hour_q <= (hour_q == BCD_23) ? bcd2_t'(0) : bcd_inc(hour_q);
    end
  end
`endif

  assign bus.hour     = hour_q;
  assign bus.minute   = min_val;
  assign bus.second   = sec_val;
  assign bus.sec_tick = sec_tick_q;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter with a 4-cycle second (CLK_HZ=4).
// Covers the 24-hour build by default and the 12-hour build with TWELVE_HOUR_EN.
module tb_time_counter;
  import clock_pkg::*;

  localparam int CLK_HZ = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  time_counter_if bus ();

  time_counter #(.CLK_HZ(CLK_HZ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef TWELVE_HOUR_EN
  localparam bcd2_t HOUR_RST = 8'h12;
`else
  localparam bcd2_t HOUR_RST = 8'h00;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_time(input string tag, input bcd2_t h, input bcd2_t m, input bcd2_t s);
    check({tag, ".hour"}, 32'(bus.hour), 32'(h));
    check({tag, ".minute"}, 32'(bus.minute), 32'(m));
    check({tag, ".second"}, 32'(bus.second), 32'(s));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic h, input logic m);
    bus.inc_hour = h;
    bus.inc_min  = m;
    @(negedge clk);
    bus.inc_hour = 1'b0;
    bus.inc_min  = 1'b0;
  endtask

  initial begin
    bus.set_mode = 1'b0;
    bus.inc_hour = 1'b0;
    bus.inc_min  = 1'b0;

    #12;
    check_time("reset", HOUR_RST, 8'h00, 8'h00);
    check("reset.sec_tick", 32'(bus.sec_tick), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    cycles(3);
    check("first.tick_early", 32'(bus.sec_tick), 32'd0);
    check("first.sec_early", 32'(bus.second), 32'h00);
    cycles(1);
    check("first.tick", 32'(bus.sec_tick), 32'd1);
    check("first.sec", 32'(bus.second), 32'h01);
    cycles(1);
    check("first.tick_drop", 32'(bus.sec_tick), 32'd0);
    cycles(3);
    check("second.tick", 32'(bus.sec_tick), 32'd1);
    check("second.sec", 32'(bus.second), 32'h02);

    // Reset mid-count with the prescaler at 2.
    cycles(2);
    #2 rst_n = 1'b0;
    #1 check_time("async_rst", HOUR_RST, 8'h00, 8'h00);
    check("async_rst.tick", 32'(bus.sec_tick), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(3);
    check("post_rst.tick_early", 32'(bus.sec_tick), 32'd0);
    cycles(1);
    check("post_rst.tick", 32'(bus.sec_tick), 32'd1);
    check("post_rst.sec", 32'(bus.second), 32'h01);

`ifdef TWELVE_HOUR_EN
    bus.set_mode = 1'b1;
    cycles(1);
    check_time("set12", 8'h12, 8'h00, 8'h00);
    pulse(1'b1, 1'b0);
    check("h12_to_01", 32'(bus.hour), 32'h01);
    check("h12_to_01.pm", 32'(bus.pm), 32'd0);
    repeat (10) pulse(1'b1, 1'b0);
    repeat (59) pulse(1'b0, 1'b1);
    check_time("preload_1159", 8'h11, 8'h59, 8'h00);
    bus.set_mode = 1'b0;
    cycles(59 * CLK_HZ);
    check_time("am_115959", 8'h11, 8'h59, 8'h59);
    check("am_115959.pm", 32'(bus.pm), 32'd0);
    cycles(CLK_HZ);
    check_time("noon", 8'h12, 8'h00, 8'h00);
    check("noon.pm", 32'(bus.pm), 32'd1);
    bus.set_mode = 1'b1;
    cycles(1);
    repeat (59) pulse(1'b0, 1'b1);
    bus.set_mode = 1'b0;
    cycles(60 * CLK_HZ);
    check_time("one_pm", 8'h01, 8'h00, 8'h00);
    check("one_pm.pm", 32'(bus.pm), 32'd1);
`else
    bus.set_mode = 1'b1;
    cycles(1);
    check("set.sec_clear", 32'(bus.second), 32'h00);
    repeat (23) pulse(1'b1, 1'b0);
    check("set.hour23", 32'(bus.hour), 32'h23);
    repeat (59) pulse(1'b0, 1'b1);
    check_time("set.2359", 8'h23, 8'h59, 8'h00);
    pulse(1'b0, 1'b1);
    check_time("min_wrap_no_carry", 8'h23, 8'h00, 8'h00);
    pulse(1'b1, 1'b0);
    check("hour_wrap_set", 32'(bus.hour), 32'h00);
    repeat (59) pulse(1'b0, 1'b1);
    repeat (23) pulse(1'b1, 1'b0);

    bus.set_mode = 1'b0;
    cycles(59 * CLK_HZ);
    check_time("pre_roll", 8'h23, 8'h59, 8'h59);
    check("pre_roll.tick", 32'(bus.sec_tick), 32'd1);
    cycles(CLK_HZ - 1);
    check("hold.tick", 32'(bus.sec_tick), 32'd0);
    check("hold.sec", 32'(bus.second), 32'h59);
    cycles(1);
    check_time("rollover", 8'h00, 8'h00, 8'h00);
    check("rollover.tick", 32'(bus.sec_tick), 32'd1);

    bus.set_mode = 1'b1;
    cycles(1);
    repeat (9) pulse(1'b1, 1'b1);
    check_time("preload_0909", 8'h09, 8'h09, 8'h00);
    pulse(1'b1, 1'b1);
    check_time("both_pulses", 8'h10, 8'h10, 8'h00);
    bus.set_mode = 1'b0;
    pulse(1'b1, 1'b1);
    check("run_pulse.hour", 32'(bus.hour), 32'h10);
    check("run_pulse.minute", 32'(bus.minute), 32'h10);

    // Park the prescaler at its terminal count, then raise set_mode on that cycle.
    bus.set_mode = 1'b1;
    cycles(1);
    bus.set_mode = 1'b0;
    cycles(CLK_HZ - 1);
    bus.set_mode = 1'b1;
    cycles(1);
    check("collide.tick", 32'(bus.sec_tick), 32'd0);
    check_time("collide", 8'h10, 8'h10, 8'h00);
    bus.set_mode = 1'b0;
    cycles(CLK_HZ - 1);
    check("resume.tick_early", 32'(bus.sec_tick), 32'd0);
    cycles(1);
    check("resume.tick", 32'(bus.sec_tick), 32'd1);
    check("resume.sec", 32'(bus.second), 32'h01);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/time_counter.md
# time_counter

Real-time-of-day counter producing BCD hour, minute and second for the alarm-compare and display stages. It divides the system clock to a 1 Hz tick, carries seconds into minutes and minutes into hours, and supports a set mode in which hours and minutes are stepped by button pulses. Its `hour` and `minute` outputs feed the downstream alarm-ring comparator directly.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency. The prescaler terminal count is `CLK_HZ-1`. Must be ≥ 2.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `set_mode` in 1: level signal; 1 = time-set mode, counting halted.
- `inc_hour` in 1: single-cycle pulse; steps the hour by one, honoured only in set mode.
- `inc_min` in 1: single-cycle pulse; steps the minute by one, honoured only in set mode.
- `hour` out 8: BCD hour as {tens[7:4], ones[3:0]}, range 00–23 (24 h build).
- `minute` out 8: BCD minute, range 00–59.
- `second` out 8: BCD second, range 00–59.
- `sec_tick` out 1: one-cycle pulse, asserted in the cycle in which `second` changes through normal counting.
- `pm` out 1: PM flag. Exists only when `TWELVE_HOUR_EN` is defined.

## Operation
- **Prescaler:** counter range 0..`CLK_HZ-1`, width `$clog2(CLK_HZ)`. The internal tick asserts when the count reaches `CLK_HZ-1`; the count then wraps to 0.
- **Run mode** (`set_mode`=0), on each tick:
  - second increments.
  - 59→00 carries into minute.
  - minute 59→00 carries into hour.
  - hour 23→00 wraps with no further carry.
- **BCD rule:** ones digit 9→0 increments tens. The modulus check uses the full two-digit value. Illegal BCD is never produced.
- **Set mode** (`set_mode`=1):
  - Prescaler held at 0.
  - `second` held at 00.
  - `sec_tick` held at 0.
  - `inc_min` steps minute modulo 60 with **no** carry into hour.
  - `inc_hour` steps hour modulo 24.
  - Both pulses in the same cycle: both apply.
  - Pulses are ignored when `set_mode`=0.
- **Leaving set mode:** the first second elapses a full `CLK_HZ` cycles after `set_mode` falls.
- **Reset:** an asynchronous `rst_n` assertion mid-count immediately forces `hour`=00, `minute`=00, `second`=00, `sec_tick`=0, `pm`=0 and prescaler=0. Counting resumes from 00:00:00.

## Timing
- All outputs are registered.
- `hour`, `minute` and `second` update on the clock edge following the cycle in which the prescaler is at `CLK_HZ-1`. `sec_tick` is high for exactly that following cycle.
- A set-mode pulse sampled high at edge N is reflected on the outputs after edge N, i.e. latency of 1 cycle.
- 23:59:59 → 00:00:00 changes all three fields on the same edge.
- `set_mode` rising in the same cycle as a tick: set mode wins. No increment occurs and `second` is cleared.

## Configuration
- `TWELVE_HOUR_EN` defined: 12-hour build.
  - `hour` ranges 01–12; reset value is 12 with `pm`=0.
  - Run-mode sequence: 11:59:59 → 12:00:00 toggles `pm`; 12:59:59 → 01:00:00 leaves `pm` unchanged.
  - In set mode, `inc_hour` steps 12→01 without touching `pm`, and 11→12 toggles `pm`.
- `TWELVE_HOUR_EN` undefined: 24-hour build as described above. The `pm` port is absent.

## Structure
- Shared package `clock_pkg` holds:
  - BCD constants `BCD_59` = 8'h59, `BCD_23` = 8'h23, `BCD_12` = 8'h12, `BCD_01` = 8'h01.
  - Typedef `bcd2_t` (logic [7:0]).
  - Function `bcd_inc(bcd2_t)`, returning the value +1 with decimal digit carry.
- Sub-module `bcd_mod_counter`, used for seconds and minutes:
  - Parameters: modulus.
  - Inputs: enable, step, clear.
  - Outputs: value, carry.
- The hour register is kept local because its wrap rules depend on `TWELVE_HOUR_EN`.

## Test plan
- **Reset:** with `CLK_HZ`=4, assert `rst_n`=0 mid-count → all outputs 00 immediately. After release, `sec_tick` pulses every 4 cycles and `second` reads 01, 02, ….
- **Full rollover:** preload via set mode to 23:59 and run 59 s → 23:59:59 followed by 00:00:00 on a single edge, with `sec_tick`=1 in that cycle.
- **Minute step without carry:** in set mode with minute 59, pulse `inc_min` → minute 00, hour unchanged, second stays 00.
- **Simultaneous pulses:** in set mode at 09:09, pulse `inc_hour` and `inc_min` in the same cycle → 10:10 one cycle later. Pulse `inc_min` with `set_mode`=0 → no change.
- **Set-mode/tick collision:** raise `set_mode` in the same cycle as the prescaler at 3 → no increment, `second`=00. Drop `set_mode` → the next `sec_tick` occurs 4 cycles later.
- **`TWELVE_HOUR_EN` build:** 11:59:59 → 12:00:00 with `pm` 0→1; 12:59:59 → 01:00:00 with `pm` still 1.
